// File: rtl/alu_rs_pkg.sv
// Shared types and sizes for the ALU reservation station.
package alu_rs_pkg;

  localparam int unsigned RS_SIZE  = 16;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ROB_ID_W = 5;
  localparam int unsigned OP_W     = 6;

  // Decoded ALU/branch operation; OP_NOP doubles as "no issue" on the ALU side.
  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 6'd0,
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU,
    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI, OP_SRLI, OP_SRAI, OP_SLTI, OP_SLTIU,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR
  } opcode_t;

  // One source operand: value once ready, producer ROB tag until then.
  typedef struct packed {
    logic [DATA_W-1:0]   value;
    logic [ROB_ID_W-1:0] tag;
    logic                ready;
  } src_t;

  typedef struct packed {
    logic                valid;
    opcode_t             optype;
    logic [DATA_W-1:0]   pc;
    logic [DATA_W-1:0]   imm;
    logic [ROB_ID_W-1:0] rd_alias;
    src_t                j;
    src_t                k;
  } rs_entry_t;

  typedef struct packed {
    logic                valid;
    logic [ROB_ID_W-1:0] tag;
    logic [DATA_W-1:0]   value;
  } cdb_t;

  // Operand bundle registered towards the ALU.
  typedef struct packed {
    opcode_t             optype;
    logic [ROB_ID_W-1:0] rd_alias;
    logic [DATA_W-1:0]   pc;
    logic [DATA_W-1:0]   rs1;
    logic [DATA_W-1:0]   rs2;
    logic [DATA_W-1:0]   imm;
  } issue_t;

  // Capture a broadcast value into a waiting source; ALU CDB has precedence.
  function automatic src_t snoop(input src_t s, input cdb_t alu, input cdb_t lsb);
    src_t r;
    r = s;
    if (!s.ready) begin
      if (alu.valid && alu.tag == s.tag) begin
        r.value = alu.value;
        r.ready = 1'b1;
      end else if (lsb.valid && lsb.tag == s.tag) begin
        r.value = lsb.value;
        r.ready = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_pick_first.sv
// Lowest-index priority picker over a request vector.
module rs_pick_first #(
  parameter int unsigned N     = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan downwards so the lowest set bit is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ops, wakes operands from the CDBs, issues one ready op per cycle.
module alu_rs
  import alu_rs_pkg::*;
(
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                clear_in,
  output logic                full_out,
  input  logic                dis_valid_in,
  input  opcode_t             dis_optype_in,
  input  logic [DATA_W-1:0]   dis_pc_in,
  input  logic [DATA_W-1:0]   dis_imm_in,
  input  logic [ROB_ID_W-1:0] dis_rd_alias_in,
  input  logic                dis_qj_rdy_in,
  input  logic                dis_qk_rdy_in,
  input  logic [DATA_W-1:0]   dis_vj_in,
  input  logic [DATA_W-1:0]   dis_vk_in,
  input  logic [ROB_ID_W-1:0] dis_qj_in,
  input  logic [ROB_ID_W-1:0] dis_qk_in,
  input  logic                alu_cdb_valid_in,
  input  logic [ROB_ID_W-1:0] alu_cdb_alias_in,
  input  logic [DATA_W-1:0]   alu_cdb_value_in,
  input  logic                lsb_cdb_valid_in,
  input  logic [ROB_ID_W-1:0] lsb_cdb_alias_in,
  input  logic [DATA_W-1:0]   lsb_cdb_value_in,
  output opcode_t             optype_out,
  output logic [ROB_ID_W-1:0] rd_alias_out,
  output logic [DATA_W-1:0]   pc_out,
  output logic [DATA_W-1:0]   rs1_out,
  output logic [DATA_W-1:0]   rs2_out,
  output logic [DATA_W-1:0]   imm_out
);

  rs_entry_t          ent_q [RS_SIZE];
  rs_entry_t          ent_d [RS_SIZE];
  issue_t             out_q;
  issue_t             out_d;
  logic [RS_SIZE-1:0] free_vec;
  logic [RS_SIZE-1:0] ready_vec;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic               iss_found;
  logic [IDX_W-1:0]   iss_idx;
  logic               dis_fire;
  cdb_t               alu_cdb;
  cdb_t               lsb_cdb;
  rs_entry_t          new_ent;

  // Per-entry request vectors for the two pickers, from pre-edge state.
  always_comb begin
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      free_vec[i]  = !ent_q[i].valid;
      ready_vec[i] = ent_q[i].valid && ent_q[i].j.ready && ent_q[i].k.ready;
    end
  end

  rs_pick_first #(.N(RS_SIZE), .IDX_W(IDX_W)) u_pick_free (
    .req   (free_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_pick_first #(.N(RS_SIZE), .IDX_W(IDX_W)) u_pick_ready (
    .req   (ready_vec),
    .found (iss_found),
    .idx   (iss_idx)
  );

  assign full_out = !free_found;
  assign dis_fire = dis_valid_in && free_found && rdy_in && !clear_in;

  assign alu_cdb = '{valid: alu_cdb_valid_in, tag: alu_cdb_alias_in, value: alu_cdb_value_in};
  assign lsb_cdb = '{valid: lsb_cdb_valid_in, tag: lsb_cdb_alias_in, value: lsb_cdb_value_in};

  // Incoming entry, with same-cycle wake-up from either CDB.
  always_comb begin
    new_ent          = '0;
    new_ent.valid    = 1'b1;
    new_ent.optype   = dis_optype_in;
    new_ent.pc       = dis_pc_in;
    new_ent.imm      = dis_imm_in;
    new_ent.rd_alias = dis_rd_alias_in;
    new_ent.j        = snoop('{value: dis_vj_in, tag: dis_qj_in, ready: dis_qj_rdy_in}, alu_cdb, lsb_cdb);
    new_ent.k        = snoop('{value: dis_vk_in, tag: dis_qk_in, ready: dis_qk_rdy_in}, alu_cdb, lsb_cdb);
  end

  // Next state: flush dominates; otherwise snoop, issue and dispatch together; frozen when not ready.
  always_comb begin
    ent_d = ent_q;
    out_d = out_q;
    if (rdy_in) begin
      if (clear_in) begin
        for (int i = 0; i < int'(RS_SIZE); i++) ent_d[i].valid = 1'b0;
        out_d.optype = OP_NOP;
      end else begin
        for (int i = 0; i < int'(RS_SIZE); i++) begin
          if (ent_q[i].valid) begin
            ent_d[i].j = snoop(ent_q[i].j, alu_cdb, lsb_cdb);
            ent_d[i].k = snoop(ent_q[i].k, alu_cdb, lsb_cdb);
          end
        end
        if (iss_found) begin
          out_d.optype          = ent_q[iss_idx].optype;
          out_d.rd_alias        = ent_q[iss_idx].rd_alias;
          out_d.pc              = ent_q[iss_idx].pc;
          out_d.rs1             = ent_q[iss_idx].j.value;
          out_d.rs2             = ent_q[iss_idx].k.value;
          out_d.imm             = ent_q[iss_idx].imm;
          ent_d[iss_idx].valid  = 1'b0;
        end else begin
          out_d.optype = OP_NOP;
        end
        if (dis_fire) ent_d[free_idx] = new_ent;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < int'(RS_SIZE); i++) ent_q[i] <= '0;
      out_q <= '0;
    end else begin
      for (int i = 0; i < int'(RS_SIZE); i++) ent_q[i] <= ent_d[i];
      out_q <= out_d;
    end
  end

  assign optype_out   = out_q.optype;
  assign rd_alias_out = out_q.rd_alias;
  assign pc_out       = out_q.pc;
  assign rs1_out      = out_q.rs1;
  assign rs2_out      = out_q.rs2;
  assign imm_out      = out_q.imm;

  // Dispatching into a full station is a producer protocol error; the op is dropped.
  assert property (@(posedge clk_in) disable iff (!rst_in)
                   !(rdy_in && !clear_in && dis_valid_in && full_out))
    else $warning("alu_rs: dispatch while full, op dropped");

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for the ALU reservation station.
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic                clk;
  logic                rst_n;
  logic                rdy;
  logic                clear;
  logic                full;
  logic                dis_valid;
  opcode_t             dis_optype;
  logic [DATA_W-1:0]   dis_pc, dis_imm, dis_vj, dis_vk;
  logic [ROB_ID_W-1:0] dis_rd, dis_qj, dis_qk;
  logic                dis_qj_rdy, dis_qk_rdy;
  logic                alu_v, lsb_v;
  logic [ROB_ID_W-1:0] alu_tag, lsb_tag;
  logic [DATA_W-1:0]   alu_val, lsb_val;
  opcode_t             optype;
  logic [ROB_ID_W-1:0] rd_alias;
  logic [DATA_W-1:0]   pc, rs1, rs2, imm;

  int vectors = 0;
  int miscompares = 0;

  alu_rs dut (
    .clk_in           (clk),
    .rst_in           (rst_n),
    .rdy_in           (rdy),
    .clear_in         (clear),
    .full_out         (full),
    .dis_valid_in     (dis_valid),
    .dis_optype_in    (dis_optype),
    .dis_pc_in        (dis_pc),
    .dis_imm_in       (dis_imm),
    .dis_rd_alias_in  (dis_rd),
    .dis_qj_rdy_in    (dis_qj_rdy),
    .dis_qk_rdy_in    (dis_qk_rdy),
    .dis_vj_in        (dis_vj),
    .dis_vk_in        (dis_vk),
    .dis_qj_in        (dis_qj),
    .dis_qk_in        (dis_qk),
    .alu_cdb_valid_in (alu_v),
    .alu_cdb_alias_in (alu_tag),
    .alu_cdb_value_in (alu_val),
    .lsb_cdb_valid_in (lsb_v),
    .lsb_cdb_alias_in (lsb_tag),
    .lsb_cdb_value_in (lsb_val),
    .optype_out       (optype),
    .rd_alias_out     (rd_alias),
    .pc_out           (pc),
    .rs1_out          (rs1),
    .rs2_out          (rs2),
    .imm_out          (imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rdy = 1'b1; clear = 1'b0; dis_valid = 1'b0;
    alu_v = 1'b0; lsb_v = 1'b0;
  endtask

  task automatic set_dis(input opcode_t op, input logic [31:0] p, input logic [31:0] im,
                         input logic [4:0] rd, input logic jr, input logic [31:0] vj,
                         input logic [4:0] qj, input logic kr, input logic [31:0] vk,
                         input logic [4:0] qk);
    dis_valid = 1'b1; dis_optype = op; dis_pc = p; dis_imm = im; dis_rd = rd;
    dis_qj_rdy = jr; dis_vj = vj; dis_qj = qj; dis_qk_rdy = kr; dis_vk = vk; dis_qk = qk;
  endtask

  task automatic set_alu(input logic [4:0] t, input logic [31:0] v);
    alu_v = 1'b1; alu_tag = t; alu_val = v;
  endtask

  task automatic set_lsb(input logic [4:0] t, input logic [31:0] v);
    lsb_v = 1'b1; lsb_tag = t; lsb_val = v;
  endtask

  task automatic flush();
    idle(); clear = 1'b1; step(); idle();
  endtask

  // Fill slots 0..n-1 with ADDs blocked on tag 16+i, rd=i, pc=4*i.
  task automatic fill_blocked(input int n);
    for (int i = 0; i < n; i++) begin
      set_dis(OP_ADD, 32'(i * 4), 32'h0, 5'(i), 1'b0, 32'h0, 5'(16 + i), 1'b1, 32'h0, 5'h0);
      step();
    end
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle();
    dis_optype = OP_NOP; dis_pc = '0; dis_imm = '0; dis_rd = '0; dis_vj = '0; dis_vk = '0;
    dis_qj = '0; dis_qk = '0; dis_qj_rdy = 1'b0; dis_qk_rdy = 1'b0;
    alu_tag = '0; alu_val = '0; lsb_tag = '0; lsb_val = '0;
    step(); step();
    vectors++; if (optype !== OP_NOP) begin miscompares++; $display("FAIL reset_op got %0d exp %0d", optype, OP_NOP); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %0b exp 0", full); end
    vectors++; if ({pc, rs1, rs2, imm, rd_alias} !== '0) begin miscompares++; $display("FAIL reset_data got pc=%0h rs1=%0h rs2=%0h imm=%0h rd=%0d exp 0", pc, rs1, rs2, imm, rd_alias); end
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    set_dis(OP_ADD, 32'h100, 32'h0, 5'd3, 1'b1, 32'h11, 5'd0, 1'b1, 32'h22, 5'd0);
    step(); idle();
    vectors++; if (optype !== OP_NOP) begin miscompares++; $display("FAIL add_early got %0d exp %0d", optype, OP_NOP); end
    step();
    vectors++; if (optype !== OP_ADD) begin miscompares++; $display("FAIL add_op got %0d exp %0d", optype, OP_ADD); end
    vectors++; if (rs1 !== 32'h11 || rs2 !== 32'h22) begin miscompares++; $display("FAIL add_srcs got %0h/%0h exp 11/22", rs1, rs2); end
    vectors++; if (rd_alias !== 5'd3 || pc !== 32'h100) begin miscompares++; $display("FAIL add_rd_pc got %0d/%0h exp 3/100", rd_alias, pc); end
    step();
    vectors++; if (optype !== OP_NOP || rs1 !== 32'h11) begin miscompares++; $display("FAIL add_after got op=%0d rs1=%0h exp %0d/11", optype, rs1, OP_NOP); end
  endtask

  task automatic test_wakeup();
    flush();
    set_dis(OP_ADDI, 32'h200, 32'h7, 5'd4, 1'b0, 32'h0, 5'd5, 1'b1, 32'h0, 5'd0);
    step(); idle();
    set_alu(5'd6, 32'hDEAD);
    step(); idle();
    set_alu(5'd5, 32'h10);
    step(); idle();
    vectors++; if (optype !== OP_NOP) begin miscompares++; $display("FAIL wake_early got %0d exp %0d rs1=%0h", optype, OP_NOP, rs1); end
    step();
    vectors++; if (optype !== OP_ADDI || rs1 !== 32'h10) begin miscompares++; $display("FAIL wake_issue got op=%0d rs1=%0h exp %0d/10", optype, rs1, OP_ADDI); end
    vectors++; if (imm !== 32'h7 || rd_alias !== 5'd4) begin miscompares++; $display("FAIL wake_fields got imm=%0h rd=%0d exp 7/4", imm, rd_alias); end
  endtask

  task automatic test_same_cycle();
    flush();
    set_dis(OP_SUB, 32'h300, 32'h0, 5'd8, 1'b1, 32'h1, 5'd0, 1'b0, 32'h0, 5'd7);
    set_lsb(5'd7, 32'hABCD);
    step(); idle();
    vectors++; if (optype !== OP_NOP) begin miscompares++; $display("FAIL same_early got %0d exp %0d", optype, OP_NOP); end
    step();
    vectors++; if (optype !== OP_SUB || rs2 !== 32'hABCD || rs1 !== 32'h1) begin miscompares++; $display("FAIL same_issue got op=%0d rs1=%0h rs2=%0h exp %0d/1/abcd", optype, rs1, rs2, OP_SUB); end
  endtask

  task automatic test_full();
    flush();
    fill_blocked(16);
    vectors++; if (full !== 1'b1 || optype !== OP_NOP) begin miscompares++; $display("FAIL full_set got full=%0b op=%0d exp 1/%0d", full, optype, OP_NOP); end
    set_dis(OP_XOR, 32'hBAD, 32'h0, 5'd30, 1'b1, 32'h0, 5'd0, 1'b1, 32'h0, 5'd0);
    step(); idle();
    vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL full_drop got %0b exp 1", full); end
    step();
    vectors++; if (optype !== OP_NOP) begin miscompares++; $display("FAIL full_drop_issue got op=%0d pc=%0h exp %0d", optype, pc, OP_NOP); end
    set_alu(5'd19, 32'h33);
    step(); idle();
    vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL full_wake got %0b exp 1", full); end
    step();
    vectors++; if (optype !== OP_ADD || rd_alias !== 5'd3 || rs1 !== 32'h33 || pc !== 32'hC) begin miscompares++; $display("FAIL full_e3 got op=%0d rd=%0d rs1=%0h pc=%0h exp %0d/3/33/c", optype, rd_alias, rs1, pc, OP_ADD); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL full_freed got %0b exp 0", full); end
    set_dis(OP_OR, 32'h300, 32'h0, 5'd20, 1'b1, 32'h5, 5'd0, 1'b1, 32'h6, 5'd0);
    step(); idle();
    vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL full_reuse got %0b exp 1", full); end
    step();
    vectors++; if (optype !== OP_OR || rd_alias !== 5'd20 || rs1 !== 32'h5 || full !== 1'b0) begin miscompares++; $display("FAIL full_reuse_issue got op=%0d rd=%0d rs1=%0h full=%0b exp %0d/20/5/0", optype, rd_alias, rs1, full, OP_OR); end
  endtask

  task automatic test_priority();
    flush();
    fill_blocked(10);
    set_alu(5'd18, 32'h2);
    set_lsb(5'd25, 32'h9);
    step(); idle();
    vectors++; if (optype !== OP_NOP) begin miscompares++; $display("FAIL prio_early got %0d exp %0d", optype, OP_NOP); end
    step();
    vectors++; if (rd_alias !== 5'd2 || rs1 !== 32'h2 || optype !== OP_ADD) begin miscompares++; $display("FAIL prio_first got rd=%0d rs1=%0h exp 2/2", rd_alias, rs1); end
    step();
    vectors++; if (rd_alias !== 5'd9 || rs1 !== 32'h9 || optype !== OP_ADD) begin miscompares++; $display("FAIL prio_second got rd=%0d rs1=%0h exp 9/9", rd_alias, rs1); end
    step();
    vectors++; if (optype !== OP_NOP) begin miscompares++; $display("FAIL prio_done got %0d exp %0d", optype, OP_NOP); end
  endtask

  task automatic test_clear();
    flush();
    fill_blocked(6);
    clear = 1'b1;
    set_dis(OP_AND, 32'h400, 32'h0, 5'd7, 1'b1, 32'h1, 5'd0, 1'b1, 32'h2, 5'd0);
    step(); idle();
    vectors++; if (optype !== OP_NOP || full !== 1'b0) begin miscompares++; $display("FAIL clear_now got op=%0d full=%0b exp %0d/0", optype, full, OP_NOP); end
    set_alu(5'd16, 32'h1); set_lsb(5'd17, 32'h2);
    step(); idle();
    vectors++; if (optype !== OP_NOP) begin miscompares++; $display("FAIL clear_dis_dropped got op=%0d rd=%0d exp %0d", optype, rd_alias, OP_NOP); end
    step();
    vectors++; if (optype !== OP_NOP) begin miscompares++; $display("FAIL clear_entries got op=%0d rd=%0d exp %0d", optype, rd_alias, OP_NOP); end
  endtask

  task automatic test_freeze_reset();
    flush();
    fill_blocked(16);
    set_alu(5'd16, 32'h40);
    step(); idle();
    step();
    vectors++; if (optype !== OP_ADD || rd_alias !== 5'd0 || rs1 !== 32'h40 || full !== 1'b0) begin miscompares++; $display("FAIL frz_pre got op=%0d rd=%0d rs1=%0h full=%0b exp %0d/0/40/0", optype, rd_alias, rs1, full, OP_ADD); end
    rdy = 1'b0; clear = 1'b1;
    set_dis(OP_AND, 32'h500, 32'h0, 5'd9, 1'b1, 32'h1, 5'd0, 1'b1, 32'h2, 5'd0);
    set_alu(5'd17, 32'h41);
    for (int c = 0; c < 2; c++) begin
      step();
      vectors++; if (optype !== OP_ADD || rd_alias !== 5'd0 || full !== 1'b0) begin miscompares++; $display("FAIL frz_hold%0d got op=%0d rd=%0d full=%0b exp %0d/0/0", c, optype, rd_alias, full, OP_ADD); end
    end
    idle();
    step();
    vectors++; if (optype !== OP_NOP) begin miscompares++; $display("FAIL frz_cdb_ignored got op=%0d rd=%0d exp %0d", optype, rd_alias, OP_NOP); end
    set_alu(5'd17, 32'h42);
    step(); idle();
    step();
    vectors++; if (optype !== OP_ADD || rd_alias !== 5'd1 || rs1 !== 32'h42) begin miscompares++; $display("FAIL frz_resume got op=%0d rd=%0d rs1=%0h exp %0d/1/42", optype, rd_alias, rs1, OP_ADD); end
    #3 rst_n = 1'b0;
    #1;
    vectors++; if (optype !== OP_NOP || rs1 !== 32'h0 || full !== 1'b0) begin miscompares++; $display("FAIL async_rst got op=%0d rs1=%0h full=%0b exp %0d/0/0", optype, rs1, full, OP_NOP); end
    @(negedge clk); rst_n = 1'b1;
    set_alu(5'd18, 32'h43);
    step(); idle();
    step();
    vectors++; if (optype !== OP_NOP) begin miscompares++; $display("FAIL rst_entries got op=%0d rd=%0d exp %0d", optype, rd_alias, OP_NOP); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_wakeup();
    test_same_cycle();
    test_full();
    test_priority();
    test_clear();
    test_freeze_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
